// File: rtl/pipe_phy_handshake_rsp.sv
// PHY-side responder for PIPE power_down / rate / receiver-detect handshakes.
// Optional protocol checker on proto_err is built only when PIPE_HS_CHECK_EN is defined.
module pipe_phy_handshake_rsp #(
    parameter int RESET_DLY = 16,
    parameter int PD_DLY    = 8,
    parameter int RATE_DLY  = 12,
    parameter int DET_DLY   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] power_down,
    input  logic [3:0] rate,
    input  logic       tx_detect_rx,
    input  logic       rx_present,
    output logic       phy_status,
    output logic [2:0] rx_status,
    output logic       rx_elec_idle,
    output logic [3:0] cur_power_down,
    output logic [3:0] cur_rate,
    output logic       busy,
    output logic       proto_err
);

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        PD_CHG,
        RATE_CHG,
        DETECT,
        ACK
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_lim_d;
    logic [3:0] target_q;
    logic       phy_status_q;
    logic [2:0] rx_status_q;
    logic       elec_idle_q;
    logic [3:0] cur_pd_q;
    logic [3:0] cur_rate_q;
    logic       busy_q;
    logic       det_armed_q;

    always_comb begin
        cnt_lim_d = 8'(PD_DLY);
        case (state_q)
            RATE_CHG: cnt_lim_d = 8'(RATE_DLY);
            DETECT:   cnt_lim_d = 8'(DET_DLY);
            default:  cnt_lim_d = 8'(PD_DLY);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RST_WAIT;
            cnt_q        <= 8'd0;
            target_q     <= 4'd0;
            phy_status_q <= 1'b1;
            rx_status_q  <= 3'b000;
            elec_idle_q  <= 1'b1;
            cur_pd_q     <= 4'd2;
            cur_rate_q   <= 4'd0;
            busy_q       <= 1'b1;
            det_armed_q  <= 1'b1;
        end else begin
            // A low request re-arms detection; the detect ack below may clear it.
            if (!tx_detect_rx) begin
                det_armed_q <= 1'b1;
            end
            case (state_q)
                RST_WAIT: begin
                    if (cnt_q == 8'(RESET_DLY - 1)) begin
                        cnt_q        <= 8'd0;
                        phy_status_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (power_down != cur_pd_q) begin
                        target_q <= power_down;
                        busy_q   <= 1'b1;
                        state_q  <= PD_CHG;
                    end else if (rate != cur_rate_q) begin
                        target_q <= rate;
                        busy_q   <= 1'b1;
                        state_q  <= RATE_CHG;
                    end else if (cur_pd_q == 4'd2 && tx_detect_rx && det_armed_q) begin
                        busy_q  <= 1'b1;
                        state_q <= DETECT;
                    end
                end
                PD_CHG, RATE_CHG, DETECT: begin
                    if (cnt_q == cnt_lim_d) begin
                        phy_status_q <= 1'b1;
                        state_q      <= ACK;
                        if (state_q == PD_CHG) begin
                            cur_pd_q    <= target_q;
                            elec_idle_q <= (target_q != 4'd0);
                        end else if (state_q == RATE_CHG) begin
                            cur_rate_q <= target_q;
                        end else begin
                            rx_status_q <= {1'b0, rx_present, rx_present};
                            if (tx_detect_rx) begin
                                det_armed_q <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ACK: begin
                    phy_status_q <= 1'b0;
                    rx_status_q  <= 3'b000;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= RST_WAIT;
                end
            endcase
        end
    end

    assign phy_status     = phy_status_q;
    assign rx_status      = rx_status_q;
    assign rx_elec_idle   = elec_idle_q;
    assign cur_power_down = cur_pd_q;
    assign cur_rate       = cur_rate_q;
    assign busy           = busy_q;

`ifdef PIPE_HS_CHECK_EN
    logic [3:0] pd_prev_q;
    logic [3:0] rate_prev_q;
    logic       err_q;
    logic       viol_d;

    always_comb begin
        viol_d = (tx_detect_rx && cur_pd_q != 4'd2)
              || (busy_q && (power_down != pd_prev_q || rate != rate_prev_q))
              || (state_q == IDLE && power_down > 4'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd_prev_q   <= 4'd2;
            rate_prev_q <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            pd_prev_q   <= power_down;
            rate_prev_q <= rate;
            if (viol_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
